uart_tx_datapath: RTL and testbench

UART_TX_DATAPATH -- requirements
Module: uart_tx_datapath

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_datapath.sv | 67 ++++++
 tb/tb_uart_tx_datapath.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared constants: default data/divisor widths and the frame-length derivation.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV_W  = 16;

  // start bit + data bits + stop bit
  function automatic int frame_bits(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: tick pulses on the last clock of each bit-time (divisor 0 acts as 1).
// Latency: tick is combinational from the count register; count wraps on the edge after tick.
// Backpressure: none; counting is gated by en and forced to zero by clr.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;
  logic             at_end;

  // >= rather than == so a divisor lowered below the running count still wraps next edge
  always_comb begin
    last_cnt = (div == '0) ? '0 : div - ONE;
    at_end   = (cnt >= last_cnt);
    tick     = en && !reset && at_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: frame shift register, saturating bit counter, registered line driver.
// Latency: one cycle from tx_sel/shreg to tx; shift_done decoded directly from bit_cnt.
// Backpressure: none; sequencing is owned by the external controller strobes.
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              load,
  input  logic              tx_sel,
  input  logic              tx_shift_en,
  input  logic              cnt_en,
  output logic              baud_comp,
  output logic              shift_done,
  output logic              tx
);

  localparam int FRAME_BITS = frame_bits(DATA_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tx_sel),
    .clr   (load),
    .div   (baud_div),
    .tick  (baud_comp)
  );

  assign shift_done = (bit_cnt == CNT_MAX);

  // load has priority over both shift and count so a mid-frame load restarts cleanly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '1;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      if (load) begin
        shreg <= {1'b1, tx_data, 1'b0};
      end else if (tx_shift_en) begin
        shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
      end

      if (load) begin
        bit_cnt <= '0;
      end else if (cnt_en && !shift_done) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end

      tx <= tx_sel ? shreg[0] : 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Scoreboard bench for uart_tx_datapath: a bench-side controller drives frames, pushes
// per-cycle expectations, and a monitor compares them against the DUT outputs.
module tb_uart_tx_datapath;
  import uart_pkg::*;

  localparam int K_TX  = 0;
  localparam int K_SD  = 1;
  localparam int K_BC  = 2;
  localparam int K_CNT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_data;
  logic [15:0] baud_div;
  logic        load;
  logic        tx_sel;
  logic        tx_shift_en;
  logic        cnt_en;
  logic        baud_comp;
  logic        shift_done;
  logic        tx;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  uart_tx_datapath #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .baud_div    (baud_div),
    .load        (load),
    .tx_sel      (tx_sel),
    .tx_shift_en (tx_shift_en),
    .cnt_en      (cnt_en),
    .baud_comp   (baud_comp),
    .shift_done  (shift_done),
    .tx          (tx)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_sig(input string name, input int kind, input int exp);
    item_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input int e_tx, input int e_sd,
                            input int e_bc, input int e_cnt);
    expect_sig({tag, " tx"}, K_TX, e_tx);
    expect_sig({tag, " shift_done"}, K_SD, e_sd);
    expect_sig({tag, " baud_comp"}, K_BC, e_bc);
    expect_sig({tag, " bit_cnt"}, K_CNT, e_cnt);
  endtask

  // Monitor: expectations for a cycle are queued at negedge+1, compared at negedge+2.
  initial begin
    item_t e;
    int    act;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          K_TX:    act = (tx === 1'b1) ? 1 : ((tx === 1'b0) ? 0 : -1);
          K_SD:    act = (shift_done === 1'b1) ? 1 : ((shift_done === 1'b0) ? 0 : -1);
          K_BC:    act = (baud_comp === 1'b1) ? 1 : ((baud_comp === 1'b0) ? 0 : -1);
          default: act = int'(dut.bit_cnt);
        endcase
        chk(e.name, act, e.exp);
      end
    end
  end

  // One frame with a bench-side controller. frame is {stop, data, start}, bit 0 sent first.
  // stop_after != 0 abandons the frame after that many shifts (no idle cycle appended).
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [15:0] div,
                           input logic [9:0] frame, input int eff, input int stop_after);
    int k;
    int shifts;
    bit done;
    int e_tx;
    int e_cnt;
    @(negedge clk);
    load = 1'b1; tx_data = data; baud_div = div; tx_sel = 1'b0;
    tx_shift_en = 1'b1; cnt_en = 1'b1;
    k = 0; shifts = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      load = 1'b0; tx_sel = 1'b1;
      #1;
      tx_shift_en = baud_comp && !shift_done;
      cnt_en      = tx_shift_en;
      if (k == 0 || k > 10 * eff) e_tx = 1;
      else e_tx = int'(frame[(k - 1) / eff]);
      e_cnt = (k / eff > 10) ? 10 : k / eff;
      expect_all($sformatf("%s k=%0d", tag, k), e_tx, (k >= 10 * eff) ? 1 : 0,
                 (k % eff == eff - 1) ? 1 : 0, e_cnt);
      if (tx_shift_en) shifts++;
      if (shift_done === 1'b1) begin
        done = 1'b1;
        chk({tag, " frame_len"}, k + 1, 10 * eff + 1);
      end else if (stop_after != 0 && shifts == stop_after) begin
        done = 1'b1;
      end else if (k >= 10 * eff + 4) begin
        done = 1'b1;
        chk({tag, " timeout"}, k, 10 * eff);
      end
      k++;
    end
    if (stop_after == 0) begin
      @(negedge clk);
      tx_sel = 1'b0; tx_shift_en = 1'b0; cnt_en = 1'b0;
      #1;
      expect_all({tag, " idle"}, 1, 1, 0, 10);
    end
  endtask

  // Asynchronous reset pulse; baud_div=1 with tx_sel=1 would tick if reset did not gate it.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    baud_div = 16'd1; tx_sel = 1'b1; tx_shift_en = 1'b0; cnt_en = 1'b0; load = 1'b0;
    #1;
    reset = 1'b1;
    expect_all({tag, " async"}, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    expect_all({tag, " held"}, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; tx_sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; tx_data = 8'h00; baud_div = 16'd1;
    tx_sel = 1'b1; tx_shift_en = 1'b0; cnt_en = 1'b0;
    @(negedge clk);
    #1;
    expect_all("reset", 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; tx_sel = 1'b0;

    run_frame("a5_div4", 8'hA5, 16'd4, 10'h34A, 4, 0);
    run_frame("00_div1", 8'h00, 16'd1, 10'h200, 1, 0);
    run_frame("00_div0", 8'h00, 16'd0, 10'h200, 1, 0);

    run_frame("ff_abort", 8'hFF, 16'd2, 10'h3FE, 2, 3);
    run_frame("3c_restart", 8'h3C, 16'd2, 10'h278, 2, 0);

    pulse_reset("rst_idle");
    run_frame("rst_mid", 8'h00, 16'd4, 10'h200, 4, 5);
    pulse_reset("rst_mid");
    run_frame("a5_after_rst", 8'hA5, 16'd4, 10'h34A, 4, 0);

    // Divisor lowered from 100 to 4 while the count sits at 50.
    @(negedge clk);
    load = 1'b1; tx_data = 8'h55; baud_div = 16'd100; tx_sel = 1'b0;
    tx_shift_en = 1'b0; cnt_en = 1'b0;
    for (int k = 0; k <= 62; k++) begin
      @(negedge clk);
      load = 1'b0; tx_sel = 1'b1;
      if (k == 50) baud_div = 16'd4;
      #1;
      tx_shift_en = baud_comp;
      cnt_en      = baud_comp;
      expect_sig($sformatf("divchg k=%0d baud_comp", k), K_BC,
                 (k == 50 || (k > 50 && (k - 50) % 4 == 0)) ? 1 : 0);
    end

    @(negedge clk);
    tx_sel = 1'b0; tx_shift_en = 1'b0; cnt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
